// File: rtl/pa_pkg.sv
// Shared instruction-format definitions for the encoder and the CPU decoder.
// Field positions, opcode set, immediate range and encoder FSM states.
package pa_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpShl  = 4'd5,
    OpShr  = 4'd6,
    OpAddi = 4'd7,
    OpLd   = 4'd8,
    OpSt   = 4'd9,
    OpBeq  = 4'd10,
    OpJmp  = 4'd11
  } opcode_e;

  localparam int unsigned NUM_OPCODES = 12;

  localparam int unsigned OFFSET_MSB = 31;
  localparam int unsigned OFFSET_LSB = 19;
  localparam int unsigned RA_MSB     = 18;
  localparam int unsigned RA_LSB     = 14;
  localparam int unsigned RB_MSB     = 13;
  localparam int unsigned RB_LSB     = 9;
  localparam int unsigned RD_MSB     = 8;
  localparam int unsigned RD_LSB     = 4;
  localparam int unsigned OPCODE_MSB = 3;
  localparam int unsigned OPCODE_LSB = 0;

  localparam int IMM_MIN = -4096;
  localparam int IMM_MAX = 4095;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } enc_state_e;

  function automatic logic [31:0] encode_instr(input logic [3:0]  opcode,
                                               input logic [4:0]  rd,
                                               input logic [4:0]  ra,
                                               input logic [4:0]  rb,
                                               input logic [12:0] offset);
    logic [31:0] w;
    w = '0;
    w[OFFSET_MSB:OFFSET_LSB] = offset;
    w[RA_MSB:RA_LSB]         = ra;
    w[RB_MSB:RB_LSB]         = rb;
    w[RD_MSB:RD_LSB]         = rd;
    w[OPCODE_MSB:OPCODE_LSB] = opcode;
    return w;
  endfunction

  function automatic logic imm_fits(input logic [31:0] imm);
    return ($signed(imm) >= IMM_MIN) && ($signed(imm) <= IMM_MAX);
  endfunction

endpackage

// File: rtl/pa_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; Depth must be a power of two.
// Push when full and pop when empty are ignored.
module pa_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_en, pop_en;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pa_instr_encoder.sv
// Packs instruction fields into decoder-format words and streams them to instruction memory.
// Define PA_ENC_IMM_CHECK_EN to drop instructions whose immediate does not fit in 13 bits.
module pa_instr_encoder
  import pa_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [3:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        ra_i,
  input  logic [4:0]        rb_i,
  input  logic [31:0]       imm_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);

  enc_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  logic        fifo_full, fifo_empty;
  logic        accept, push, pop, drop;
  logic        opcode_ok, imm_ok, instr_ok;
  logic [31:0] enc_word;

  assign opcode_ok = (32'(opcode_i) < NUM_OPCODES);

`ifdef PA_ENC_IMM_CHECK_EN
  assign imm_ok = imm_fits(imm_i);
`else
  // Upper immediate bits are discarded by truncation; OR-ing them in keeps them consumed.
  assign imm_ok = 1'b1 | (^imm_i[31:13]);
`endif

  assign instr_ok  = opcode_ok && imm_ok;
  assign in_ready_o = (state_q == StRun) && !fifo_full;
  assign accept    = in_valid_i && in_ready_o;
  assign push      = accept && instr_ok;
  assign drop      = accept && !instr_ok;
  assign imem_we_o = !fifo_empty && ((state_q == StRun) || (state_q == StFlush));
  assign pop       = imem_we_o && imem_ready_i;
  assign enc_word  = encode_instr(opcode_i, rd_i, ra_i, rb_i, imm_i[12:0]);

  pa_sync_fifo #(
    .Width(32),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .wdata_i(enc_word),
    .pop_i  (pop),
    .rdata_o(imem_wdata_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StRun;
            addr_q    <= base_addr_i;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
          end
        end
        StRun:   if (accept && in_last_i) state_q <= StFlush;
        StFlush: if (fifo_empty) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      // Pops and drops only happen in RUN/FLUSH, so they never collide with the start load.
      if (pop) addr_q <= addr_q + 1'b1;
      if (drop) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign imem_addr_o = addr_q;
  assign busy_o      = (state_q == StRun) || (state_q == StFlush);
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_pa_instr_encoder.sv
// Self-checking bench for pa_instr_encoder: directed cases plus randomized programs
// compared against a word-level model of the instruction layout and write sequence.
module tb_pa_instr_encoder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic              in_last_i = 1'b0;
  logic [3:0]        opcode_i = '0;
  logic [4:0]        rd_i = '0, ra_i = '0, rb_i = '0;
  logic [31:0]       imm_i = '0;
  logic              imem_we_o;
  logic              imem_ready_i = 1'b1;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              busy_o, done_o, err_o;
  logic [7:0]        err_cnt_o;

  int checks = 0;
  int errors = 0;

  // 0: memory always ready, 1: random, 2: always stalled
  int ready_mode = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  int                exp_next_addr;
  int                exp_err;

  pa_instr_encoder #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_last_i   (in_last_i),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .ra_i        (ra_i),
    .rb_i        (rb_i),
    .imm_i       (imm_i),
    .imem_we_o   (imem_we_o),
    .imem_ready_i(imem_ready_i),
    .imem_addr_o (imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor and hold-while-stalled check, sampled mid-cycle.
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_we_hold", {63'd0, imem_we_o}, 64'd1);
        check("stall_addr_hold", {54'd0, imem_addr_o}, {54'd0, prev_addr});
        check("stall_data_hold", {32'd0, imem_wdata_o}, {32'd0, prev_data});
      end
      if (imem_we_o && imem_ready_i) begin
        wr_addr.push_back(imem_addr_o);
        wr_data.push_back(imem_wdata_o);
      end
      prev_stall <= imem_we_o && !imem_ready_i;
      prev_addr  <= imem_addr_o;
      prev_data  <= imem_wdata_o;
    end
  end

  function automatic logic [31:0] model_word(input int op, input int rd, input int ra,
                                             input int rb, input int imm);
    longint unsigned off;
    longint unsigned w;
    off = longint'(imm) & 64'h1FFF;
    w = off * 524288 + longint'(ra) * 16384 + longint'(rb) * 512 + longint'(rd) * 16
        + longint'(op);
    return w[31:0];
  endfunction

  function automatic bit model_legal(input int op, input int imm);
    bit ok;
    ok = (op < 12);
`ifdef PA_ENC_IMM_CHECK_EN
    ok = ok && (imm >= -4096) && (imm <= 4095);
`else
    ok = ok && (imm == imm);
`endif
    return ok;
  endfunction

  task automatic cyc();
    case (ready_mode)
      0:       imem_ready_i = 1'b1;
      1:       imem_ready_i = 1'($urandom_range(0, 1));
      default: imem_ready_i = 1'b0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic begin_prog(input int base);
    wr_addr.delete();
    wr_data.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_next_addr = base;
    exp_err = 0;
    start_i = 1'b1;
    base_addr_i = ADDR_W'(base);
    cyc();
    start_i = 1'b0;
    check("ready_after_start", {63'd0, in_ready_o}, 64'd1);
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
  endtask

  task automatic send(input int op, input int rd, input int ra, input int rb, input int imm,
                      input bit last);
    int n;
    opcode_i = op[3:0];
    rd_i = rd[4:0];
    ra_i = ra[4:0];
    rb_i = rb[4:0];
    imm_i = imm;
    in_last_i = last;
    in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 300) begin
      cyc();
      n++;
    end
    if (n >= 300) begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      cyc();
      if (model_legal(op, imm)) begin
        exp_addr_q.push_back(ADDR_W'(exp_next_addr));
        exp_data_q.push_back(model_word(op, rd, ra, rb, imm));
        exp_next_addr = (exp_next_addr + 1) % (1 << ADDR_W);
      end else begin
        exp_err++;
      end
    end
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
  endtask

  task automatic end_prog(input string tag);
    int dc;
    dc = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_o) dc++;
      if (dc > 0 && !done_o) break;
      cyc();
    end
    check({tag, "_done_pulses"}, 64'(dc), 64'd1);
    check({tag, "_busy_end"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_err"}, {63'd0, err_o}, {63'd0, exp_err != 0});
    check({tag, "_err_cnt"}, {56'd0, err_cnt_o}, 64'((exp_err > 255) ? 255 : exp_err));
    check({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, {54'd0, wr_addr[i]}, {54'd0, exp_addr_q[i]});
      check({tag, "_data"}, {32'd0, wr_data[i]}, {32'd0, exp_data_q[i]});
    end
  endtask

  function automatic logic [63:0] got_addr(input int i);
    return (i < wr_addr.size()) ? {54'd0, wr_addr[i]} : 64'hx;
  endfunction

  function automatic logic [63:0] got_data(input int i);
    return (i < wr_data.size()) ? {32'd0, wr_data[i]} : 64'hx;
  endfunction

  initial begin
    // Reset state
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    check("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
    check("rst_we", {63'd0, imem_we_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt_o}, 64'd0);
    check("rst_addr", {54'd0, imem_addr_o}, 64'd0);

    // Basic encode, including first-presentation latency
    ready_mode = 0;
    begin_prog(32'h010);
    send(3, 5, 1, 2, 10, 1'b1);
    check("basic_we_next", {63'd0, imem_we_o}, 64'd1);
    check("basic_wdata_next", {32'd0, imem_wdata_o}, 64'h0050_4453);
    end_prog("basic");
    check("basic_addr_const", got_addr(0), 64'h010);
    check("basic_data_const", got_data(0), 64'h0050_4453);

    // Negative immediate
    begin_prog(32'h020);
    send(0, 0, 0, 0, -1, 1'b1);
    end_prog("negimm");
    check("negimm_data_const", got_data(0), 64'hFFF8_0000);

    // Illegal opcode in the middle; a start pulse while running must be ignored
    begin_prog(32'h040);
    send(1, 1, 2, 3, 7, 1'b0);
    start_i = 1'b1;
    base_addr_i = 10'h155;
    cyc();
    start_i = 1'b0;
    send(14, 4, 4, 4, 4, 1'b0);
    send(2, 6, 7, 8, -20, 1'b1);
    end_prog("illegal");
    check("illegal_addr0", got_addr(0), 64'h040);
    check("illegal_addr1", got_addr(1), 64'h041);
    check("illegal_err_cnt_const", {56'd0, err_cnt_o}, 64'd1);

    // Backpressure: FIFO fills, in_ready drops, then drains in order
    ready_mode = 2;
    begin_prog(32'h100);
    for (int i = 0; i < 4; i++) send(i, i + 1, i + 2, i + 3, i * 100, 1'b0);
    check("bp_ready_low_full", {63'd0, in_ready_o}, 64'd0);
    check("bp_we_high", {63'd0, imem_we_o}, 64'd1);
    cyc();
    cyc();
    check("bp_no_writes", 64'(wr_addr.size()), 64'd0);
    ready_mode = 0;
    send(4, 9, 10, 11, -300, 1'b1);
    end_prog("bp");

    // Address wrap and out-of-range immediate
    begin_prog(32'h3FF);
    send(5, 1, 1, 1, 1, 1'b0);
    send(6, 2, 2, 2, 2, 1'b0);
    send(7, 3, 3, 3, 4096, 1'b1);
    end_prog("wrap");
    check("wrap_addr0", got_addr(0), 64'h3FF);
    check("wrap_addr1", got_addr(1), 64'h000);

    // Empty program: only instruction dropped
    begin_prog(32'h080);
    send(15, 0, 0, 0, 0, 1'b1);
    check("empty_we_low", {63'd0, imem_we_o}, 64'd0);
    end_prog("empty");

    // Randomized programs with random memory backpressure and input gaps
    ready_mode = 1;
    for (int p = 0; p < 6; p++) begin
      int len;
      begin_prog(int'($urandom_range(0, (1 << ADDR_W) - 1)));
      len = int'($urandom_range(3, 12));
      for (int k = 0; k < len; k++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) cyc();
        send(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 10000)) - 5000, k == len - 1);
      end
      end_prog("rand");
    end

    // Reset mid-load with three entries buffered
    ready_mode = 2;
    begin_prog(32'h200);
    for (int i = 0; i < 3; i++) send(1, i, i, i, i, 1'b0);
    check("midrst_we_before", {63'd0, imem_we_o}, 64'd1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    check("midrst_we", {63'd0, imem_we_o}, 64'd0);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready_o}, 64'd0);
    check("midrst_addr", {54'd0, imem_addr_o}, 64'd0);
    ready_mode = 0;
    for (int i = 0; i < 10; i++) cyc();
    check("midrst_no_writes", 64'(wr_addr.size()), 64'd0);
    check("midrst_idle_busy", {63'd0, busy_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
